oh_clkgate_ctrl: RTL and testbench

Clock-gate enable sequencer for one gated clock domain shared by N requesters. It produces a registered enable for the downstream active-low-latch clock gate, which captures the enable while clk=0 so the gated clock is glitch-free. The block wakes the domain on demand, waits a fixed settle time, then grants requesters with a req/ack handshake. After a programmable number of idle cycles it gates the clock off again.

---
 rtl/oh_clkgate_ctrl.sv | 103 ++++++++++
 tb/tb_oh_clkgate_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/oh_clkgate_ctrl.sv
// Clock-gate enable sequencer: wakes the shared domain on demand, settles WAKE cycles, grants req/ack, gates off after idle hold-off.
// Latency: gate_en 1 cycle after activity in OFF, ack WAKE+1 cycles after req; no backpressure, requesters hold req until ack.
module oh_clkgate_ctrl #(
  parameter int N    = 2,
  parameter int IW   = 8,
  parameter int WAKE = 2
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [IW-1:0] idle_cycles,
  input  logic          force_on,
  input  logic          busy,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  ack,
  output logic          gate_en,
  output logic          clk_on
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    wcnt, wcnt_nxt;
  logic [IW-1:0] icnt, icnt_nxt;
  logic [N-1:0]  ack_nxt;
  logic          gate_en_nxt;
  logic          clk_on_nxt;
  logic          act;

  assign act = (|req) | busy | force_on;

  // All outputs are flops so the latch-based gate never sees a combinational glitch.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= ST_OFF;
      wcnt    <= '0;
      icnt    <= '0;
      ack     <= '0;
      gate_en <= 1'b0;
      clk_on  <= 1'b0;
    end else begin
      state   <= state_nxt;
      wcnt    <= wcnt_nxt;
      icnt    <= icnt_nxt;
      ack     <= ack_nxt;
      gate_en <= gate_en_nxt;
      clk_on  <= clk_on_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    icnt_nxt  = icnt;
    case (state)
      ST_OFF: begin
        if (act) begin
          state_nxt = ST_WAKE;
          wcnt_nxt  = 4'(WAKE - 1);
        end
      end
      ST_WAKE: begin
        // A request dropping here does not abort the wake; the domain still reaches ON.
        if (wcnt == '0) begin
          state_nxt = ST_ON;
        end else begin
          wcnt_nxt = wcnt - 4'd1;
        end
      end
      ST_ON: begin
        if (!act) begin
          if (idle_cycles != '0) begin
            state_nxt = ST_HOLD;
            icnt_nxt  = idle_cycles - IW'(1);
          end else begin
            state_nxt = ST_OFF;
          end
        end
      end
      ST_HOLD: begin
        if (act) begin
          state_nxt = ST_ON;
        end else if (icnt == '0) begin
          state_nxt = ST_OFF;
        end else begin
          icnt_nxt = icnt - IW'(1);
        end
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  always_comb begin
    ack_nxt     = req & {N{state_nxt == ST_ON}};
    gate_en_nxt = (state_nxt != ST_OFF);
    clk_on_nxt  = (state_nxt == ST_ON) || (state_nxt == ST_HOLD);
  end

endmodule

// File: tb/tb_oh_clkgate_ctrl.sv
// Bench for oh_clkgate_ctrl: directed wake/idle/force/reset sequences plus randomized traffic,
// all outputs compared every cycle against a timestamp-based domain model.
module tb_oh_clkgate_ctrl;
  localparam int N    = 2;
  localparam int IW   = 8;
  localparam int WAKE = 2;

  logic          clk = 1'b0;
  logic          nreset;
  logic [IW-1:0] idle_cycles;
  logic          force_on;
  logic          busy;
  logic [N-1:0]  req;
  logic [N-1:0]  ack;
  logic          gate_en;
  logic          clk_on;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  oh_clkgate_ctrl #(.N(N), .IW(IW), .WAKE(WAKE)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .idle_cycles (idle_cycles),
    .force_on    (force_on),
    .busy        (busy),
    .req         (req),
    .ack         (ack),
    .gate_en     (gate_en),
    .clk_on      (clk_on)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Domain model: powered flag, cycle at which the clock becomes usable, and a run length of idle cycles.
  bit           pwr       = 1'b0;
  int           cyc       = 0;
  int           ready_cyc = 0;
  int           idle_run  = 0;
  int           hold_lim  = 0;
  bit           m_act     = 1'b0;
  logic [N-1:0] exp_ack   = '0;
  logic         exp_gate  = 1'b0;
  logic         exp_on    = 1'b0;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pwr = 1'b0; cyc = 0; idle_run = 0;
      exp_ack = '0; exp_gate = 1'b0; exp_on = 1'b0;
    end else begin
      m_act = (|req) | busy | force_on;
      if (!pwr) begin
        if (m_act) begin
          pwr       = 1'b1;
          ready_cyc = cyc + 1 + WAKE;
          exp_gate  = 1'b1;
        end
        exp_on  = 1'b0;
        exp_ack = '0;
      end else if (cyc + 1 < ready_cyc) begin
        exp_on  = 1'b0;
        exp_ack = '0;
      end else if (cyc + 1 == ready_cyc || m_act) begin
        idle_run = 0;
        exp_on   = 1'b1;
        exp_ack  = req;
      end else begin
        if (idle_run == 0) hold_lim = int'(idle_cycles);
        idle_run++;
        exp_ack = '0;
        if (idle_run > hold_lim) begin
          pwr      = 1'b0;
          exp_gate = 1'b0;
          exp_on   = 1'b0;
        end else begin
          exp_on = 1'b1;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (nreset === 1'b1) begin
      check("model.ack", 32'(ack), 32'(exp_ack));
      check("model.gate_en", 32'(gate_en), 32'(exp_gate));
      check("model.clk_on", 32'(clk_on), 32'(exp_on));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic g, input logic c, input logic [N-1:0] a);
    check({tag, ".gate_en"}, 32'(gate_en), 32'(g));
    check({tag, ".clk_on"}, 32'(clk_on), 32'(c));
    check({tag, ".ack"}, 32'(ack), 32'(a));
  endtask

  initial begin
    nreset = 1'b0; idle_cycles = 8'd4; force_on = 1'b0; busy = 1'b0; req = 2'b00;
    #3 expect_out("reset", 1'b0, 1'b0, 2'b00);
    @(posedge clk); #2 nreset = 1'b1;
    step(2);

    // Wake from OFF
    req = 2'b01;
    expect_out("wake.t0", 1'b0, 1'b0, 2'b00);
    step(1); expect_out("wake.t1", 1'b1, 1'b0, 2'b00);
    step(1); expect_out("wake.t2", 1'b1, 1'b0, 2'b00);
    step(1); expect_out("wake.on", 1'b1, 1'b1, 2'b01);
    for (int i = 0; i < 4; i++) begin
      step(1); expect_out("wake.held", 1'b1, 1'b1, 2'b01);
    end

    // Idle hold-off then gate off
    req = 2'b00;
    step(1); expect_out("idle.ack_drop", 1'b1, 1'b1, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step(1); expect_out("idle.hold", 1'b1, 1'b1, 2'b00);
    end
    step(1); expect_out("idle.off", 1'b0, 1'b0, 2'b00);

    // Re-request during HOLD
    req = 2'b01;
    step(3); expect_out("rereq.on", 1'b1, 1'b1, 2'b01);
    req = 2'b00;
    step(1); expect_out("rereq.hold1", 1'b1, 1'b1, 2'b00);
    step(1); expect_out("rereq.hold2", 1'b1, 1'b1, 2'b00);
    req = 2'b10;
    step(1); expect_out("rereq.on2", 1'b1, 1'b1, 2'b10);

    // Zero idle with both requesters
    idle_cycles = 8'd0; req = 2'b11;
    step(1); expect_out("zero.both", 1'b1, 1'b1, 2'b11);
    req = 2'b00;
    step(1); expect_out("zero.off", 1'b0, 1'b0, 2'b00);

    // force_on keeps the domain up with no acks
    idle_cycles = 8'd4; force_on = 1'b1;
    step(1); expect_out("force.wake", 1'b1, 1'b0, 2'b00);
    step(2); expect_out("force.on", 1'b1, 1'b1, 2'b00);
    for (int i = 0; i < 10; i++) begin
      step(1); expect_out("force.stay", 1'b1, 1'b1, 2'b00);
    end
    force_on = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1); expect_out("force.hold", 1'b1, 1'b1, 2'b00);
    end
    step(1); expect_out("force.off", 1'b0, 1'b0, 2'b00);

    // busy behaves as activity, including return from HOLD
    busy = 1'b1;
    step(3); expect_out("busy.on", 1'b1, 1'b1, 2'b00);
    busy = 1'b0;
    step(1); expect_out("busy.hold", 1'b1, 1'b1, 2'b00);
    busy = 1'b1; req = 2'b01;
    step(1); expect_out("busy.back_on", 1'b1, 1'b1, 2'b01);
    busy = 1'b0; req = 2'b00;
    step(6); expect_out("busy.off", 1'b0, 1'b0, 2'b00);

    // Async reset mid-WAKE, then full wake repeats
    req = 2'b01;
    step(1); expect_out("arst.pre", 1'b1, 1'b0, 2'b00);
    #2 nreset = 1'b0;
    #1 expect_out("arst.wake", 1'b0, 1'b0, 2'b00);
    step(1); expect_out("arst.held", 1'b0, 1'b0, 2'b00);
    #2 nreset = 1'b1;
    step(1); expect_out("arst.rewake1", 1'b1, 1'b0, 2'b00);
    step(1); expect_out("arst.rewake2", 1'b1, 1'b0, 2'b00);
    step(1); expect_out("arst.reon", 1'b1, 1'b1, 2'b01);

    // Async reset mid-ON
    #2 nreset = 1'b0;
    #1 expect_out("arst.on", 1'b0, 1'b0, 2'b00);
    step(1);
    #2 nreset = 1'b1;
    step(3); expect_out("arst.reon2", 1'b1, 1'b1, 2'b01);
    req = 2'b00;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step(1);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(7) == 0) req[i] = 1'b1;
        end else if ((ack[i] && $urandom_range(5) == 0) || $urandom_range(60) == 0) begin
          req[i] = 1'b0;
        end
      end
      if (!busy) begin
        if ($urandom_range(29) == 0) busy = 1'b1;
      end else if ($urandom_range(2) == 0) begin
        busy = 1'b0;
      end
      if (!force_on) begin
        if ($urandom_range(199) == 0) force_on = 1'b1;
      end else if ($urandom_range(19) == 0) begin
        force_on = 1'b0;
      end
      if ($urandom_range(40) == 0)
        idle_cycles = ($urandom_range(9) == 0) ? IW'($urandom_range(255)) : IW'($urandom_range(5));
      if ($urandom_range(700) == 0) begin
        #1 nreset = 1'b0;
        #1 nreset = 1'b1;
      end
    end

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
